multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
Execute-stage multiply/divide unit. It consumes the decode-stage control fields is_multdiv and mult_type, together with register operands read after decode, and returns one RV64M result per accepted request. MUL/MULW are single-cycle registered. DIV/DIVU/REM/REMU and their W forms use an iterative radix-2 restoring divider. The pipeline stalls on ready_o and done_o.

Parameters:
XLEN, 64, operand/result width
WLEN, 32, width of W-variant operations

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
valid_i  in  1  request valid (ctl.is_multdiv of issuing instruction)
mult_type_i  in  mult_t  operation select from decode_pkg (MULT_MUL, MULT_DIV, MULT_DIVU, MULT_REM, MULT_REMU, MULT_MULW, MULT_DIVW, MULT_DIVUW, MULT_REMW, MULT_REMUW)
a_i  in  XLEN  rs1 value (dividend / multiplicand)
b_i  in  XLEN  rs2 value (divisor / multiplier)
flush_i  in  1  kill in-flight operation (pipeline redirect)
ready_o  out  1  unit idle, may accept
done_o  out  1  result valid, one-cycle pulse
result_o  out  XLEN  result, held until next acceptance

Behaviour:
- Reset (async, resetn=0): state=IDLE; ready_o=1; done_o=0; result_o=0; counter and all datapath registers=0.
- States:
  - IDLE: ready_o=1.
  - DIV: iterate.
  - FIX: sign/width correction.
  - DONE: done_o=1, ready_o=0.
- Accept: valid_i && ready_o && !flush_i at a rising edge. valid_i while not ready is ignored; the request is not queued.
- MUL/MULW, IDLE -> DONE:
  - MUL result = low XLEN bits of a_i*b_i.
  - MULW result = sign-extend(low 32 bits of a_i[31:0]*b_i[31:0]).
  - done_o is high in the cycle after acceptance.
- Divide special cases, IDLE -> DONE, done_o the cycle after acceptance:
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0.
  - W forms evaluate both cases on the 32-bit operands, then sign-extend the result.
- Normal divide, IDLE -> DIV:
  - Latch absolute values for signed ops. W forms use a_i[31:0]/b_i[31:0], sign- or zero-extended per signedness.
  - Latch quotient sign = sa^sb and remainder sign = sa.
  - counter = N, where N = XLEN, or WLEN for W forms.
- DIV iteration, one quotient bit per cycle: shift {rem,quo} left by 1; trial-subtract the divisor; keep the result if non-negative and set the quotient LSB. Decrement the counter; counter reaching 0 moves to FIX.
- FIX: negate quotient/remainder per latched signs. W forms sign-extend bit 31 of the selected value. Select quotient or remainder per op. Write result_o. Go to DONE.
- DONE -> IDLE after one cycle. result_o is unchanged until the next acceptance.
- Latency, for acceptance in cycle 0:
  - Normal divide: done_o in cycle N+2 (66 for 64-bit, 34 for W).
  - MUL and special cases: done_o in cycle 1.
- flush_i in any state: next state IDLE, no done_o pulse, result_o unchanged. flush_i together with valid_i in IDLE means no acceptance.
- flush_i arriving in the same cycle that done_o is high has no effect on that pulse; the unit returns to IDLE anyway.
- resetn asserted mid-operation: immediate return to reset values; no done_o.
- Unsigned ops never negate. DIVU/REMU with a 64-bit dividend use the full width; no sign handling.

Test Plan:
- MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3) -> done_o in cycle 1, result 0xFFFF_FFFF_FFFF_FFEB; ready_o low only during DONE.
- DIV a=-7, b=2 -> result 0xFFFF_FFFF_FFFF_FFFD (-3) with done_o at cycle 66. REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU a=123, b=0 -> 0xFFFF_FFFF_FFFF_FFFF at cycle 1. REMU a=123, b=0 -> 123. DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000. REM with the same operands -> 0.
- DIVW a=0x1234_5678_8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 at cycle 1. REMUW a=0xFFFF_FFFF_0000_0007, b=3 -> 1 at cycle 34.
- Start DIV 100/7, assert flush_i at cycle 20 -> no done_o, ready_o=1 at cycle 21. A new MULW 0x7FFF_FFFF*2 accepted in that cycle gives 0xFFFF_FFFF_FFFF_FFFE at cycle 22.
- Deassert resetn at cycle 10 of a DIV -> ready_o=1, done_o=0, result_o=0 immediately. valid_i held during DIV is never accepted twice.

Source files
------------

// File: rtl/multdiv_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// mult_type_i carries a decode_pkg::mult_t encoding.
interface multdiv_unit_if #(
  parameter int XLEN = 64
);
  logic            valid_i;
  logic [3:0]      mult_type_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            ready_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, mult_type_i, a_i, b_i, flush_i,
    input  ready_o, done_o, result_o
  );

  modport slave (
    input  valid_i, mult_type_i, a_i, b_i, flush_i,
    output ready_o, done_o, result_o
  );
endinterface

// File: rtl/multdiv_unit.sv
// RV64M execute-stage multiply/divide unit: registered MUL/MULW,
// radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms.
package decode_pkg;
  typedef enum logic [3:0] {
    MULT_MUL,
    MULT_DIV,
    MULT_DIVU,
    MULT_REM,
    MULT_REMU,
    MULT_MULW,
    MULT_DIVW,
    MULT_DIVUW,
    MULT_REMW,
    MULT_REMUW
  } mult_t;
endpackage

module multdiv_unit
  import decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic             clk,
  input  logic             resetn,
  multdiv_unit_if.slave    bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int EW = XLEN - WLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] result_q;
  logic            negq_q;
  logic            negr_q;
  logic            w_q;
  logic            remop_q;

  mult_t op;
  logic  is_mul, is_w, is_sgn, is_rem;

  assign op = mult_t'(bus.mult_type_i);

  always_comb begin
    is_mul = 1'b0;
    is_w   = 1'b0;
    is_sgn = 1'b0;
    is_rem = 1'b0;
    unique case (op)
      MULT_MUL:   is_mul = 1'b1;
      MULT_MULW:  begin is_mul = 1'b1; is_w = 1'b1; end
      MULT_DIV:   is_sgn = 1'b1;
      MULT_DIVU:  ;
      MULT_REM:   begin is_sgn = 1'b1; is_rem = 1'b1; end
      MULT_REMU:  is_rem = 1'b1;
      MULT_DIVW:  begin is_w = 1'b1; is_sgn = 1'b1; end
      MULT_DIVUW: is_w = 1'b1;
      MULT_REMW:  begin
        is_w = 1'b1; is_sgn = 1'b1; is_rem = 1'b1;
      end
      MULT_REMUW: begin is_w = 1'b1; is_rem = 1'b1; end
      default:    ;
    endcase
  end

  logic [WLEN-1:0] aw, bw, prodw;
  logic [XLEN-1:0] a, b, prod;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic [XLEN-1:0] a_sel, mul_res, spec_res;
  logic            sa, sb, b_zero, ovf;

  assign a     = bus.a_i;
  assign b     = bus.b_i;
  assign aw    = a[WLEN-1:0];
  assign bw    = b[WLEN-1:0];
  assign prod  = a * b;
  assign prodw = aw * bw;

  assign sa = is_sgn & (is_w ? aw[WLEN-1] : a[XLEN-1]);
  assign sb = is_sgn & (is_w ? bw[WLEN-1] : b[XLEN-1]);

  assign a_ext = is_w ? {{EW{sa}}, aw} : a;
  assign b_ext = is_w ? {{EW{sb}}, bw} : b;
  assign a_abs = sa ? -a_ext : a_ext;
  assign b_abs = sb ? -b_ext : b_ext;

  assign b_zero = is_w ? (bw == '0) : (b == '0);
  assign ovf    = is_sgn & (is_w
                ? (aw == {1'b1, {(WLEN-1){1'b0}}}) && (&bw)
                : (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b));

  assign a_sel    = is_w ? {{EW{aw[WLEN-1]}}, aw} : a;
  assign mul_res  = is_w ? {{EW{prodw[WLEN-1]}}, prodw} : prod;
  assign spec_res = b_zero ? (is_rem ? a_sel : '1)
                           : (is_rem ? '0 : a_sel);

  // Partial remainder is always below the divisor, so one extra
  // bit is enough for the shifted trial value and the borrow flag.
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;

  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = ~diff[XLEN];

  logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_res;

  assign q_fix   = negq_q ? -quo_q : quo_q;
  assign r_fix   = negr_q ? -rem_q : rem_q;
  assign sel_fix = remop_q ? r_fix : q_fix;
  assign fix_res = w_q ? {{EW{sel_fix[WLEN-1]}}, sel_fix[WLEN-1:0]}
                       : sel_fix;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      w_q      <= 1'b0;
      remop_q  <= 1'b0;
    end else if (bus.flush_i) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.valid_i) begin
            if (is_mul) begin
              result_q <= mul_res;
              state_q  <= S_DONE;
            end else if (b_zero || ovf) begin
              result_q <= spec_res;
              state_q  <= S_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= is_w ? {a_abs[WLEN-1:0], {EW{1'b0}}}
                              : a_abs;
              dvs_q   <= b_abs;
              negq_q  <= sa ^ sb;
              negr_q  <= sa;
              w_q     <= is_w;
              remop_q <= is_rem;
              cnt_q   <= is_w ? CW'(WLEN) : CW'(XLEN);
              state_q <= S_DIV;
            end
          end
        end
        S_DIV: begin
          rem_q <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], ge};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_res;
          state_q  <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: latency, results, flush and
// asynchronous reset behaviour.
module tb_multdiv_unit;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  multdiv_unit_if #(.XLEN(64)) mif ();

  multdiv_unit #(.XLEN(64), .WLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (mif)
  );

  int errs = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  task automatic start_op(input mult_t op, input logic [63:0] a,
                          input logic [63:0] b, input bit hold);
    @(negedge clk);
    checks++;
    if (mif.ready_o !== 1'b1) begin
      errs++;
      $display("FAIL ready_before_accept got=%b want=1", mif.ready_o);
    end
    mif.valid_i     = 1'b1;
    mif.mult_type_i = op;
    mif.a_i         = a;
    mif.b_i         = b;
    @(posedge clk);
    #1;
    if (!hold) mif.valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat);
    int cyc = 1;
    bit busy_bad = 0;
    logic [63:0] exp;
    while (mif.done_o !== 1'b1 && cyc < 200) begin
      if (mif.ready_o !== 1'b0) busy_bad = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (mif.done_o !== 1'b1) begin
      errs++;
      $display("FAIL %s timeout got_done=%b want=1", nm, mif.done_o);
      void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (cyc !== lat) begin
        errs++;
        $display("FAIL %s latency got=%0d want=%0d", nm, cyc, lat);
      end
      checks++;
      if (mif.result_o !== exp) begin
        errs++;
        $display("FAIL %s result got=%h want=%h", nm, mif.result_o, exp);
      end
      checks++;
      if (mif.ready_o !== 1'b0 || busy_bad) begin
        errs++;
        $display("FAIL %s ready_busy got=%b/%b want=0/0",
                 nm, mif.ready_o, busy_bad);
      end
      mif.valid_i = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (mif.result_o !== exp || mif.done_o !== 1'b0 ||
          mif.ready_o !== 1'b1) begin
        errs++;
        $display("FAIL %s after_done res=%h done=%b rdy=%b want=%h/0/1",
                 nm, mif.result_o, mif.done_o, mif.ready_o, exp);
      end
    end
  endtask

  task automatic run_op(input string nm, input mult_t op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    start_op(op, a, b, 0);
    exp_q.push_back(exp);
    wait_done(nm, lat);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mif.ready_o !== 1'b1 || mif.done_o !== 1'b0 ||
        mif.result_o !== 64'd0) begin
      errs++;
      $display("FAIL reset got rdy=%b done=%b res=%h want 1/0/0",
               mif.ready_o, mif.done_o, mif.result_o);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mul;
    run_op("mul", MULT_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
           64'hFFFF_FFFF_FFFF_FFEB, 1);
    run_op("mulw", MULT_MULW, 64'hAAAA_0000_0001_0000,
           64'h5555_0000_0000_8000, 64'hFFFF_FFFF_8000_0000, 1);
  endtask

  task automatic test_div;
    run_op("div_neg", MULT_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op("rem_neg", MULT_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("divu_full", MULT_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
           64'h0FFF_FFFF_FFFF_FFFF, 66);
    run_op("remu_full", MULT_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
           64'hF, 66);
  endtask

  task automatic test_special;
    run_op("divu_zero", MULT_DIVU, 64'd123, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_zero", MULT_REMU, 64'd123, 64'd0, 64'd123, 1);
    run_op("div_ovf", MULT_DIV, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", MULT_REM, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
  endtask

  task automatic test_wform;
    run_op("divw_ovf", MULT_DIVW, 64'h1234_5678_8000_0000,
           64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remuw", MULT_REMUW, 64'hFFFF_FFFF_0000_0007, 64'd3,
           64'd1, 34);
    run_op("remw_neg", MULT_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("divuw", MULT_DIVUW, 64'hDEAD_0000_FFFF_FFFF, 64'd2,
           64'h0000_0000_7FFF_FFFF, 34);
  endtask

  task automatic test_flush;
    bit saw_done = 0;
    logic [63:0] prev;
    prev = mif.result_o;
    start_op(MULT_DIV, 64'd100, 64'd7, 0);
    repeat (19) begin
      @(posedge clk);
      #1;
      if (mif.done_o === 1'b1) saw_done = 1;
    end
    mif.flush_i = 1'b1;
    mif.valid_i = 1'b1;
    @(posedge clk);
    #1;
    mif.flush_i = 1'b0;
    mif.valid_i = 1'b0;
    checks++;
    if (saw_done || mif.done_o !== 1'b0 || mif.ready_o !== 1'b1 ||
        mif.result_o !== prev) begin
      errs++;
      $display("FAIL flush got done=%b/%b rdy=%b res=%h want 0/0/1/%h",
               saw_done, mif.done_o, mif.ready_o, mif.result_o, prev);
    end
    run_op("mulw_after_flush", MULT_MULW, 64'h7FFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFE, 1);
  endtask

  task automatic test_valid_held;
    int dones = 0;
    start_op(MULT_DIV, 64'd100, 64'd7, 1);
    exp_q.push_back(64'd14);
    wait_done("div_held", 66);
    repeat (80) begin
      @(posedge clk);
      #1;
      if (mif.done_o === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errs++;
      $display("FAIL held_no_reaccept got=%0d want=0", dones);
    end
  endtask

  task automatic test_reset_mid;
    start_op(MULT_DIV, 64'd100, 64'd7, 0);
    repeat (9) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (mif.ready_o !== 1'b1 || mif.done_o !== 1'b0 ||
        mif.result_o !== 64'd0) begin
      errs++;
      $display("FAIL reset_mid got rdy=%b done=%b res=%h want 1/0/0",
               mif.ready_o, mif.done_o, mif.result_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    run_op("div_after_reset", MULT_DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
           64'hFFFF_FFFF_FFFF_FFF2, 66);
  endtask

  initial begin
    mif.valid_i     = 1'b0;
    mif.mult_type_i = 4'd0;
    mif.a_i         = '0;
    mif.b_i         = '0;
    mif.flush_i     = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_wform();
    test_flush();
    test_valid_held();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
